transfer_sequencer: RTL and testbench

- Control-side initiator for the 16-bit transfer register. It turns a single START/CMD request into correctly timed load, select and assert strobes.
- The transfer register loads on the falling edge of LOAD_LOW/LOAD_HIGH. This block therefore raises a load line, holds it for a programmed time, then drops it while LOAD_SELECT is stable.
- It also sequences the bus drivers (ASSERT_*_bar) so that no two drivers of the main bus are ever enabled together.
- Sits between the microcode/decoder and the transfer register.

---
 rtl/transfer_sequencer_if.sv | 30 +++
 rtl/transfer_sequencer.sv | 157 +++++++++++++++
 tb/tb_transfer_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/transfer_sequencer_if.sv
// Control/strobe bundle between the microcode side and the transfer sequencer.
// master = requester (microcode/decoder), slave = transfer_sequencer.
interface transfer_sequencer_if;
   logic       START;
   logic [2:0] CMD;
   logic       BUSY;
   logic       DONE;
   logic       LOAD_LOW;
   logic       LOAD_HIGH;
   logic       LOAD_SELECT;
   logic       ASSERT_LOW_bar;
   logic       ASSERT_HIGH_bar;
   logic       ASSERT_ADDR_bar;
   logic       BYTE_STROBE;
   logic       BYTE_INDEX;

   modport master (
      output START, CMD,
      input  BUSY, DONE, LOAD_LOW, LOAD_HIGH, LOAD_SELECT,
             ASSERT_LOW_bar, ASSERT_HIGH_bar, ASSERT_ADDR_bar,
             BYTE_STROBE, BYTE_INDEX
   );

   modport slave (
      input  START, CMD,
      output BUSY, DONE, LOAD_LOW, LOAD_HIGH, LOAD_SELECT,
             ASSERT_LOW_bar, ASSERT_HIGH_bar, ASSERT_ADDR_bar,
             BYTE_STROBE, BYTE_INDEX
   );
endinterface

// File: rtl/transfer_sequencer.sv
// Turns START/CMD into timed load, select and bus-drive strobes for the 16-bit transfer register.
// Optional TRANSFER_SEQ_TURNAROUND_EN adds a deasserted turnaround cycle (GAP) before the next bus owner.
module transfer_sequencer #(
   parameter int unsigned PULSE_CYCLES = 1,
   parameter int unsigned DRIVE_CYCLES = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   transfer_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE, SETUP, PULSE, DRIVE_LO, GAP, DRIVE_HI, DRIVE_ADDR, RELEASE
   } state_t;

   localparam logic [2:0] CMD_NOP            = 3'd0;
   localparam logic [2:0] CMD_LOAD_ADDR      = 3'd1;
   localparam logic [2:0] CMD_LOAD_LOW_MAIN  = 3'd2;
   localparam logic [2:0] CMD_LOAD_HIGH_MAIN = 3'd3;
   localparam logic [2:0] CMD_STORE_ADDR     = 3'd4;
   localparam logic [2:0] CMD_STORE_LOW      = 3'd5;
   localparam logic [2:0] CMD_STORE_HIGH     = 3'd6;
   localparam logic [2:0] CMD_STORE_WORD     = 3'd7;

   localparam int unsigned PULSE_EFF  = (PULSE_CYCLES == 0) ? 32'd1 : PULSE_CYCLES;
   localparam int unsigned DRIVE_EFF  = (DRIVE_CYCLES == 0) ? 32'd1 : DRIVE_CYCLES;
   localparam logic [3:0]  PULSE_LOAD = 4'(PULSE_EFF - 32'd1);
   localparam logic [3:0]  DRIVE_LOAD = 4'(DRIVE_EFF - 32'd1);

`ifdef TRANSFER_SEQ_TURNAROUND_EN
   localparam state_t POST_STATE = GAP;
   localparam state_t WORD_MID   = GAP;
`else
   localparam state_t POST_STATE = RELEASE;
   localparam state_t WORD_MID   = DRIVE_HI;
`endif

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [2:0] cmd_q, cmd_nxt;
   logic       load_sel_nxt;

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      cmd_nxt      = cmd_q;
      load_sel_nxt = bus.LOAD_SELECT;
      case (state)
         IDLE: begin
            if (bus.START) begin
               cmd_nxt = bus.CMD;
               case (bus.CMD)
                  CMD_NOP: state_nxt = RELEASE;
                  CMD_LOAD_ADDR, CMD_LOAD_LOW_MAIN, CMD_LOAD_HIGH_MAIN: begin
                     state_nxt    = SETUP;
                     cnt_nxt      = '0;
                     load_sel_nxt = (bus.CMD != CMD_LOAD_ADDR);
                  end
                  CMD_STORE_ADDR: begin
                     state_nxt = DRIVE_ADDR;
                     cnt_nxt   = DRIVE_LOAD;
                  end
                  CMD_STORE_LOW, CMD_STORE_WORD: begin
                     state_nxt = DRIVE_LO;
                     cnt_nxt   = DRIVE_LOAD;
                  end
                  default: begin
                     state_nxt = DRIVE_HI;
                     cnt_nxt   = DRIVE_LOAD;
                  end
               endcase
            end
         end
         SETUP: begin
            state_nxt = PULSE;
            cnt_nxt   = PULSE_LOAD;
         end
         PULSE: begin
            if (cnt == '0) state_nxt = POST_STATE;
            else           cnt_nxt   = cnt - 4'd1;
         end
         DRIVE_LO: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 4'd1;
            end else if (cmd_q == CMD_STORE_WORD) begin
               state_nxt = WORD_MID;
               cnt_nxt   = DRIVE_LOAD;
            end else begin
               state_nxt = POST_STATE;
            end
         end
         // GAP serves both the word turnaround and the trailing idle cycle of other commands.
         GAP: begin
            if (cmd_q == CMD_STORE_WORD) begin
               state_nxt = DRIVE_HI;
               cnt_nxt   = DRIVE_LOAD;
            end else begin
               state_nxt = RELEASE;
            end
         end
         DRIVE_HI: begin
            if (cnt != '0)                    cnt_nxt   = cnt - 4'd1;
            else if (cmd_q == CMD_STORE_WORD) state_nxt = RELEASE;
            else                              state_nxt = POST_STATE;
         end
         DRIVE_ADDR: begin
            if (cnt == '0) state_nxt = POST_STATE;
            else           cnt_nxt   = cnt - 4'd1;
         end
         RELEASE: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they are registered yet aligned with the state.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state               <= IDLE;
         cnt                 <= '0;
         cmd_q               <= CMD_NOP;
         bus.BUSY            <= 1'b0;
         bus.DONE            <= 1'b0;
         bus.LOAD_LOW        <= 1'b0;
         bus.LOAD_HIGH       <= 1'b0;
         bus.LOAD_SELECT     <= 1'b1;
         bus.ASSERT_LOW_bar  <= 1'b1;
         bus.ASSERT_HIGH_bar <= 1'b1;
         bus.ASSERT_ADDR_bar <= 1'b1;
         bus.BYTE_STROBE     <= 1'b0;
         bus.BYTE_INDEX      <= 1'b0;
      end else begin
         state               <= state_nxt;
         cnt                 <= cnt_nxt;
         cmd_q               <= cmd_nxt;
         bus.BUSY            <= (state_nxt != IDLE);
         bus.DONE            <= (state_nxt == RELEASE);
         bus.LOAD_LOW        <= (state_nxt == PULSE) &&
                                ((cmd_nxt == CMD_LOAD_ADDR) || (cmd_nxt == CMD_LOAD_LOW_MAIN));
         bus.LOAD_HIGH       <= (state_nxt == PULSE) &&
                                ((cmd_nxt == CMD_LOAD_ADDR) || (cmd_nxt == CMD_LOAD_HIGH_MAIN));
         bus.LOAD_SELECT     <= load_sel_nxt;
         bus.ASSERT_LOW_bar  <= (state_nxt != DRIVE_LO);
         bus.ASSERT_HIGH_bar <= (state_nxt != DRIVE_HI);
         bus.ASSERT_ADDR_bar <= (state_nxt != DRIVE_ADDR);
         bus.BYTE_STROBE     <= ((state_nxt == DRIVE_LO) || (state_nxt == DRIVE_HI)) &&
                                (cnt_nxt == '0);
         bus.BYTE_INDEX      <= (state_nxt == DRIVE_HI);
      end
   end

endmodule

// File: tb/tb_transfer_sequencer.sv
// Directed bench for transfer_sequencer: two instances (default timing, and PULSE=3/DRIVE=1).
// Output vector bits: {BUSY,DONE,LOAD_LOW,LOAD_HIGH,LOAD_SELECT,A_LOW_bar,A_HIGH_bar,A_ADDR_bar,BYTE_STROBE,BYTE_INDEX}.
module tb_transfer_sequencer;

   logic CLK = 1'b0;
   logic rst_a, rst_b;
   int   errors = 0;
   int   checks = 0;
   int   overlap = 0;
   logic [9:0] exp_q [$];

   localparam logic [9:0] RST_V = 10'b00001_11100;

   transfer_sequencer_if ifa ();
   transfer_sequencer_if ifb ();

   transfer_sequencer dut_a (.CLK(CLK), .RST(rst_a), .bus(ifa));

   transfer_sequencer #(.PULSE_CYCLES(3), .DRIVE_CYCLES(1)) dut_b (
      .CLK(CLK), .RST(rst_b), .bus(ifb)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if ((!ifa.ASSERT_LOW_bar && !ifa.ASSERT_HIGH_bar) ||
          (!ifb.ASSERT_LOW_bar && !ifb.ASSERT_HIGH_bar))
         overlap++;
   end

   function automatic logic [9:0] vec(input bit b);
      if (b)
         return {ifb.BUSY, ifb.DONE, ifb.LOAD_LOW, ifb.LOAD_HIGH, ifb.LOAD_SELECT,
                 ifb.ASSERT_LOW_bar, ifb.ASSERT_HIGH_bar, ifb.ASSERT_ADDR_bar,
                 ifb.BYTE_STROBE, ifb.BYTE_INDEX};
      return {ifa.BUSY, ifa.DONE, ifa.LOAD_LOW, ifa.LOAD_HIGH, ifa.LOAD_SELECT,
              ifa.ASSERT_LOW_bar, ifa.ASSERT_HIGH_bar, ifa.ASSERT_ADDR_bar,
              ifa.BYTE_STROBE, ifa.BYTE_INDEX};
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", tag, act, exp);
      end
   endtask

   // Checks exp_q[i] against cycle i+1; the caller is already at cycle 1.
   task automatic run_expect(input bit b, input string tag);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i > 0) begin
            @(posedge CLK);
            #1;
         end
         check($sformatf("%s_c%0d", tag, i + 1), {22'd0, vec(b)}, {22'd0, exp_q[i]});
      end
   endtask

   task automatic issue(input bit b, input logic [2:0] cmd);
      if (b) begin ifb.START = 1'b1; ifb.CMD = cmd; end
      else   begin ifa.START = 1'b1; ifa.CMD = cmd; end
      @(posedge CLK);
      #1;
      ifa.START = 1'b0;
      ifb.START = 1'b0;
   endtask

   task automatic wait_idle(input bit b, input string tag);
      logic [9:0] v;
      v = vec(b);
      for (int i = 0; i < 20; i++) begin
         if (!v[9]) break;
         @(posedge CLK);
         #1;
         v = vec(b);
      end
      check(tag, {31'd0, v[9]}, 32'd0);
   endtask

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      ifa.START = 1'b0; ifa.CMD = 3'd0;
      ifb.START = 1'b0; ifb.CMD = 3'd0;
      @(posedge CLK);
      #1;
      check("reset_a", {22'd0, vec(0)}, {22'd0, RST_V});
      check("reset_b", {22'd0, vec(1)}, {22'd0, RST_V});
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(posedge CLK);
      #1;
      check("idle_a", {22'd0, vec(0)}, {22'd0, RST_V});
      check("idle_b", {22'd0, vec(1)}, {22'd0, RST_V});

      // LOAD_ADDR, PULSE_CYCLES=1
`ifdef TRANSFER_SEQ_TURNAROUND_EN
      exp_q = {10'b10000_11100, 10'b10110_11100, 10'b10000_11100, 10'b11000_11100, 10'b00000_11100};
`else
      exp_q = {10'b10000_11100, 10'b10110_11100, 10'b11000_11100, 10'b00000_11100};
`endif
      issue(0, 3'd1);
      run_expect(0, "load_addr");

      // LOAD_HIGH_MAIN, PULSE_CYCLES=3
`ifdef TRANSFER_SEQ_TURNAROUND_EN
      exp_q = {10'b10001_11100, 10'b10011_11100, 10'b10011_11100, 10'b10011_11100,
               10'b10001_11100, 10'b11001_11100, 10'b00001_11100};
`else
      exp_q = {10'b10001_11100, 10'b10011_11100, 10'b10011_11100, 10'b10011_11100,
               10'b11001_11100, 10'b00001_11100};
`endif
      issue(1, 3'd3);
      run_expect(1, "load_high");

      // STORE_WORD, DRIVE_CYCLES=2; CMD changes after sampling and must be ignored
`ifdef TRANSFER_SEQ_TURNAROUND_EN
      exp_q = {10'b10000_01100, 10'b10000_01110, 10'b10000_11100, 10'b10000_10101,
               10'b10000_10111, 10'b11000_11100, 10'b00000_11100};
`else
      exp_q = {10'b10000_01100, 10'b10000_01110, 10'b10000_10101, 10'b10000_10111,
               10'b11000_11100, 10'b00000_11100};
`endif
      issue(0, 3'd7);
      ifa.CMD = 3'd1;
      run_expect(0, "store_word");

      // STORE_ADDR with START held high: one command, re-accepted only from IDLE
`ifdef TRANSFER_SEQ_TURNAROUND_EN
      exp_q = {10'b10000_11000, 10'b10000_11000, 10'b10000_11100, 10'b11000_11100,
               10'b00000_11100, 10'b10000_11000};
`else
      exp_q = {10'b10000_11000, 10'b10000_11000, 10'b11000_11100, 10'b00000_11100,
               10'b10000_11000};
`endif
      ifa.START = 1'b1;
      ifa.CMD   = 3'd4;
      @(posedge CLK);
      #1;
      run_expect(0, "store_addr_held");
      ifa.START = 1'b0;
      wait_idle(0, "store_addr_drain");
      check("store_addr_idle", {22'd0, vec(0)}, {22'd0, 10'b00000_11100});

      // STORE_LOW with DRIVE_CYCLES=1: strobe in the only drive cycle
`ifdef TRANSFER_SEQ_TURNAROUND_EN
      exp_q = {10'b10001_01110, 10'b10001_11100, 10'b11001_11100, 10'b00001_11100};
`else
      exp_q = {10'b10001_01110, 10'b11001_11100, 10'b00001_11100};
`endif
      issue(1, 3'd5);
      run_expect(1, "store_low");

      // Reset asserted mid-PULSE takes effect without a clock edge
      exp_q = {10'b10001_11100, 10'b10101_11100};
      issue(1, 3'd2);
      run_expect(1, "pulse_pre_rst");
      #2;
      rst_b = 1'b1;
      #1;
      check("async_reset", {22'd0, vec(1)}, {22'd0, RST_V});
      #2;
      rst_b = 1'b0;
      exp_q = {10'b11001_11100, 10'b00001_11100};
      issue(1, 3'd0);
      run_expect(1, "nop_after_rst");

      check("no_assert_overlap", overlap, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
